// File: rtl/load_store_unit.sv
// Load/store unit: takes one RV32I load or store from the core and drives a byte-addressed data memory.
// Stores write one byte per cycle, most significant byte first at the lowest address (big-endian).
// Loads do one word read, then select the byte or half-word and sign- or zero-extend it.
// Ports: clk/rst (async active-low); request start/is_store/funct3/addr/wdata;
//        status busy/done/err/rdata; memory side mem_address/mem_data_out/mem_write/mem_read/mem_rdata.
// Latency: load done at T+2, store done at T+N+1, rejected request done at T+1 (T = acceptance cycle).
// Backpressure: start is sampled only while idle; busy is high whenever a request is in flight.
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with err.
module load_store_unit #(
  parameter int MEM_BYTES = 512,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          is_store,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] mem_address,
  output logic [31:0]   mem_data_out,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  // Request decode, only meaningful while idle.
  logic [2:0]  req_size;
  logic        req_legal;
  logic [AW:0] req_last;
  logic        req_range_err;
  logic        req_misalign;
  logic        req_err;

  always_comb begin
    case (funct3[1:0])
      2'b01:   req_size = 3'd2;
      2'b10:   req_size = 3'd4;
      default: req_size = 3'd1;
    endcase
    if (is_store) req_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else          req_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                              (funct3 == 3'b100) || (funct3 == 3'b101);
    // One extra bit so an access running past the top of the address space cannot wrap back into range.
    req_last      = {1'b0, addr} + (AW+1)'(req_size) - (AW+1)'(1);
    req_range_err = req_last >= (AW+1)'(MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
    req_misalign  = ((req_size == 3'd2) && addr[0]) || ((req_size == 3'd4) && (addr[1:0] != 2'b00));
`else
    req_misalign  = 1'b0;
`endif
    req_err = !req_legal || req_range_err || req_misalign;
  end

  // Byte lane for the current store beat: wdata byte (N-1-c), so the MSB goes out first.
  logic [1:0] wr_lane;
  logic [7:0] wr_byte;
  assign wr_lane = 2'(size_q - 3'd1 - {1'b0, cnt_q});
  assign wr_byte = wdata_q[{wr_lane, 3'b000} +: 8];

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    done         = 1'b0;
    err          = 1'b0;
    mem_address  = '0;
    mem_data_out = '0;
    mem_write    = 1'b0;
    mem_read     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          funct3_d = funct3;
          addr_d   = addr;
          wdata_d  = wdata;
          size_d   = req_size;
          cnt_d    = 2'd0;
          err_d    = req_err;
          if (req_err)       state_d = FIN;
          else if (is_store) state_d = WR;
          else               state_d = RD;
        end
      end
      RD: begin
        mem_read    = 1'b1;
        mem_address = addr_q;
        case (funct3_q)
          3'b000:  rdata_d = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
          3'b100:  rdata_d = {24'd0, mem_rdata[31:24]};
          3'b001:  rdata_d = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
          3'b101:  rdata_d = {16'd0, mem_rdata[31:16]};
          default: rdata_d = mem_rdata;
        endcase
        state_d = FIN;
      end
      WR: begin
        mem_write    = 1'b1;
        mem_address  = addr_q + AW'(cnt_q);
        mem_data_out = {24'd0, wr_byte};
        if (cnt_q == 2'(size_q - 3'd1)) begin
          cnt_d   = 2'd0;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin // FIN
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;

  // Strobes are decoded from state_q, so an asynchronous reset drops mem_write immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory model, scoreboard of expected completions,
// directed loads/stores/errors, start-while-busy and mid-store reset.
module tb_load_store_unit;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          is_store = 1'b0;
  logic [2:0]    funct3 = '0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic          busy, done, err;
  logic [31:0]   rdata;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_out;
  logic          mem_write, mem_read;
  logic [31:0]   mem_rdata;

  load_store_unit #(.MEM_BYTES(512), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Byte memory model, big-endian word read.
  logic [7:0] mem [0:511];

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 8'hff);
  endfunction

  always_comb begin
    mem_rdata = {mem[mem_address[8:0]], mem[9'(mem_address[8:0] + 9'd1)],
                 mem[9'(mem_address[8:0] + 9'd2)], mem[9'(mem_address[8:0] + 9'd3)]};
  end

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } exp_t;
  exp_t sb_q[$];

  // Monitor: memory writes, strobe counting and completion scoring.
  always @(negedge clk) begin
    if (rst) begin
      if (busy) chk("strobe_excl", {31'd0, mem_read & mem_write}, 32'd0);
      if (mem_write) begin
        chk("wr_upper_zero", {8'd0, mem_data_out[31:8]}, 32'd0);
        mem[mem_address[8:0]] = mem_data_out[7:0];
        strobe_cnt++;
      end
      if (mem_read) strobe_cnt++;
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("rdata", rdata, e.rdata);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (!busy) return;
    end
    chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Drive one request and score it. poke keeps start high for two extra cycles while busy.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] w, input logic e_err, input logic [31:0] e_rd,
                        input int lat, input int n_stb, input logic poke);
    int t0, s0, d0;
    exp_t e;
    wait_idle();
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = w;
    t0 = cyc; s0 = strobe_cnt; d0 = done_cnt;
    e.err = e_err; e.rdata = e_rd; e.cyc = 32'(t0 + lat);
    sb_q.push_back(e);
    @(negedge clk); #1;
    if (poke) begin
      is_store = 1'b0; funct3 = 3'b010; addr = 32'h0;
      @(negedge clk); #1;
      @(negedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 20 && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    if (done_cnt == d0) chk("done_timeout", 32'd1, 32'd0);
    chk("strobes", 32'(strobe_cnt - s0), 32'(n_stb));
  endtask

  logic [31:0] last_rd;
  logic [31:0] w;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = pat(i);
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    last_rd = 32'h0;
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, last_rd, 5, 4, 0);
    chk("mem10", {24'd0, mem[9'h10]}, 32'hDE);
    chk("mem11", {24'd0, mem[9'h11]}, 32'hAD);
    chk("mem12", {24'd0, mem[9'h12]}, 32'hBE);
    chk("mem13", {24'd0, mem[9'h13]}, 32'hEF);
    do_req(0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2, 1, 0);

    last_rd = 32'hDEADBEEF;
    do_req(1, 3'b000, 32'h20, 32'h00000080, 0, last_rd, 2, 1, 0);
    do_req(0, 3'b000, 32'h20, 32'h0, 0, 32'hFFFFFF80, 2, 1, 0);
    do_req(0, 3'b100, 32'h20, 32'h0, 0, 32'h00000080, 2, 1, 0);

    last_rd = 32'h00000080;
    do_req(1, 3'b001, 32'h30, 32'h1234ABCD, 0, last_rd, 3, 2, 0);
    chk("mem30", {24'd0, mem[9'h30]}, 32'hAB);
    chk("mem31", {24'd0, mem[9'h31]}, 32'hCD);
    chk("mem32_keep", {24'd0, mem[9'h32]}, {24'd0, pat(32'h32)});
    do_req(0, 3'b001, 32'h30, 32'h0, 0, 32'hFFFFABCD, 2, 1, 0);
    do_req(0, 3'b101, 32'h30, 32'h0, 0, 32'h0000ABCD, 2, 1, 0);
    last_rd = 32'h0000ABCD;

    // Rejected requests: done+err one cycle after acceptance, no strobes, rdata held.
    do_req(0, 3'b010, 32'h1FE, 32'h0, 1, last_rd, 1, 0, 0);
    do_req(0, 3'b011, 32'h40, 32'h0, 1, last_rd, 1, 0, 0);
    do_req(1, 3'b100, 32'h40, 32'h55, 1, last_rd, 1, 0, 0);
    do_req(1, 3'b001, 32'h1FF, 32'h55, 1, last_rd, 1, 0, 0);

    // Top-of-memory accesses that just fit.
    do_req(1, 3'b000, 32'h1FF, 32'h0000005A, 0, last_rd, 2, 1, 0);
    chk("mem1ff", {24'd0, mem[9'h1FF]}, 32'h5A);
    w = {pat(32'h1FC), pat(32'h1FD), pat(32'h1FE), 8'h5A};
    do_req(0, 3'b010, 32'h1FC, 32'h0, 0, w, 2, 1, 0);
    last_rd = w;

`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1, 3'b010, 32'h102, 32'hCAFEF00D, 1, last_rd, 1, 0, 0);
    chk("mis_keep", {24'd0, mem[9'h102]}, {24'd0, pat(32'h102)});
`else
    do_req(1, 3'b010, 32'h102, 32'hCAFEF00D, 0, last_rd, 5, 4, 0);
    do_req(0, 3'b010, 32'h102, 32'h0, 0, 32'hCAFEF00D, 2, 1, 0);
    last_rd = 32'hCAFEF00D;
`endif

    // start held high during a store must not create a second request.
    do_req(1, 3'b010, 32'h50, 32'hA1B2C3D4, 0, last_rd, 5, 4, 1);
    begin
      int d0;
      d0 = done_cnt;
      repeat (4) @(negedge clk);
      #1;
      chk("no_extra_done", 32'(done_cnt - d0), 32'd0);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
    end
    chk("poke_mem53", {24'd0, mem[9'h53]}, 32'hD4);

    // Reset during the third byte of a word store.
    wait_idle();
    begin
      int t0;
      start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h60; wdata = 32'h11223344;
      t0 = cyc;
      @(negedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 10 && cyc != t0 + 3; i++) begin
        @(posedge clk); #1;
      end
      chk("rst_c2_write", {31'd0, mem_write}, 32'd1);
      chk("rst_c2_addr", mem_address, 32'h62);
      rst = 1'b0;
      #1;
      chk("arst_mem_write", {31'd0, mem_write}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_rdata", rdata, 32'd0);
      @(negedge clk); #1;
      rst = 1'b1;
    end
    chk("rst_m60", {24'd0, mem[9'h60]}, 32'h11);
    chk("rst_m61", {24'd0, mem[9'h61]}, 32'h22);
    chk("rst_m62", {24'd0, mem[9'h62]}, {24'd0, pat(32'h62)});
    chk("rst_m63", {24'd0, mem[9'h63]}, {24'd0, pat(32'h63)});
    w = {8'h11, 8'h22, pat(32'h62), pat(32'h63)};
    do_req(0, 3'b010, 32'h60, 32'h0, 0, w, 2, 1, 0);

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side initiator for the byte-addressed data memory.
- Takes one RV32I load/store request from the multi-cycle core and drives the memory's `mem_read`/`mem_write`/address/data pins.
- Stores are serialised into one byte write per cycle; the memory writes only `data_in[7:0]`.
- Loads are one combinational word read, then byte/half selection and sign/zero extension.
- Byte order is big-endian, matching the memory read path: `mem[a]` is the MSB of the word read at `a`.

Parameters:
- MEM_BYTES, 512, number of addressable bytes; an access touching any byte ≥ MEM_BYTES is an error.
- AW, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request strobe, sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr  in  AW  byte address.
- wdata  in  32  store data, right-justified.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: bad funct3, out-of-range address, or (with macro) misaligned access.
- rdata  out  32  extended load result, valid from done onward until the next accepted load.
- mem_address  out  AW  to memory address.
- mem_data_out  out  32  to memory data_in; byte in [7:0], [31:8] = 0.
- mem_write  out  1  to memory write enable.
- mem_read  out  1  to memory read enable.
- mem_rdata  in  32  from memory data_out.

Behaviour:
- Reset (rst=0, async):
  - State → IDLE; all outputs 0, including rdata and mem_address.
  - Byte counter cleared.
  - An in-flight store stops immediately: mem_write drops asynchronously, and bytes already written stay written.
- States: IDLE, RD, WR, FIN.
- Acceptance: start=1 in IDLE latches is_store, funct3, addr, wdata and size N (1/2/4). start is ignored in any other state.
- Error checks, evaluated at acceptance:
  - Loads: legal funct3 is 000, 001, 010, 100, 101.
  - Stores: legal funct3 is 000, 001, 010.
  - Range: error if addr + N − 1 ≥ MEM_BYTES (computed in AW+1 bits, so no wrap).
  - On error: next state FIN with err=1, no memory strobe ever asserted, rdata unchanged.
- IDLE → RD (load):
  - RD lasts exactly one cycle with mem_read=1 and mem_address=addr.
  - At the end of RD, rdata is registered:
    - LB/LBU: mem_rdata[31:24]
    - LH/LHU: mem_rdata[31:16]
    - LW: mem_rdata
  - Sign-extended for LB/LH, zero-extended for LBU/LHU.
  - Next state FIN.
- IDLE → WR (store):
  - Counter c runs 0..N−1, one cycle each, with mem_write=1 and mem_address=addr+c.
  - Byte for c is wdata byte (N−1−c), i.e. MSB first at the lowest address:
    - SW at A: A←[31:24], A+1←[23:16], A+2←[15:8], A+3←[7:0].
    - SH: A←[15:8], A+1←[7:0].
    - SB: A←[7:0].
  - After c=N−1, next state FIN.
- FIN: done=1 for exactly one cycle, err as determined, then → IDLE. start in FIN is ignored; a new request can be accepted the cycle after FIN.
- Latency, with acceptance at cycle T:
  - Load: done at T+2.
  - Store: done at T+N+1.
  - Error: done at T+1.
- Strobes: mem_read and mem_write are never high together. Both are 0 in IDLE and FIN.
- Address arithmetic: addr+c is computed mod 2^AW; the range check prevents an actual wrap.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Half access with addr[0]≠0, or word access with addr[1:0]≠0, takes the error path (FIN, err=1, no strobes).
  - Misalignment has the same priority as the other error checks.
- Undefined:
  - Misaligned accesses execute normally; the byte-addressed memory handles any alignment.
  - Latency is unchanged.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF:
  - WR cycles T+1..T+4 write 0xDE, 0xAD, 0xBE, 0xEF to 0x10..0x13.
  - done at T+5, err=0.
  - Then LW 0x10 → rdata=0xDEADBEEF at T+2.
- SB 0x20 wdata=0x00000080, then LB 0x20 → rdata=0xFFFFFF80; LBU 0x20 → 0x00000080.
- SH 0x30 wdata=0x1234ABCD:
  - Writes 0xAB@0x30, 0xCD@0x31.
  - LH 0x30 → 0xFFFFABCD; LHU 0x30 → 0x0000ABCD.
- Errors, all giving done+err at T+1 with zero strobes:
  - LW addr=0x1FE (MEM_BYTES=512).
  - Load with funct3=011.
  - SW 0x102 with LSU_MISALIGN_TRAP_EN defined; without the macro, the same access succeeds at 0x102..0x105.
- Reset and busy handling:
  - Assert rst=0 during SW at c=2: mem_write and busy drop asynchronously, state returns to IDLE.
  - After release, bytes at A, A+1 are written and A+2, A+3 are unchanged.
  - start pulsed during WR is ignored; no extra done.
